// File: rtl/set_pkg.sv
// ---------------------------------------------------------------------------
// set_pkg
// Shared constants and encodings for the SET scan/tally datapath.
//   GRID_W    : bits per grid coordinate (map is 2^GRID_W x 2^GRID_W)
//   NUM_PTS   : number of grid points walked by one scan
//   CNT_W     : width of a counter that can hold 0..NUM_PTS
//   state_e   : scan sequencer states
//   MODE_*    : set-operation encodings for combining circle A and circle B
// ---------------------------------------------------------------------------
package set_pkg;

    localparam int GRID_W  = 3;
    localparam int NUM_PTS = 1 << (2 * GRID_W);
    localparam int CNT_W   = 2 * GRID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_A   = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_OR  = 2'd2;
    localparam logic [1:0] MODE_XOR = 2'd3;

endpackage : set_pkg

// File: rtl/set_combine.sv
// ---------------------------------------------------------------------------
// set_combine
// Combinational set-operation mux: reduces the per-circle inside flags to a
// single "this point qualifies" bit.
//   mode  in  2  set operation (MODE_A / MODE_AND / MODE_OR / MODE_XOR)
//   in_a  in  1  inside flag from circle A
//   in_b  in  1  inside flag from circle B
//   sel   out 1  point qualifies under the selected operation
// ---------------------------------------------------------------------------
module set_combine (
    input  logic [1:0] mode,
    input  logic       in_a,
    input  logic       in_b,
    output logic       sel
);
    import set_pkg::*;

    always_comb begin
        sel = 1'b0;
        case (mode)
            MODE_A:   sel = in_a;
            MODE_AND: sel = in_a & in_b;
            MODE_OR:  sel = in_a | in_b;
            MODE_XOR: sel = in_a ^ in_b;
            default:  sel = 1'b0;
        endcase
    end

endmodule : set_combine

// File: rtl/set_scan_ctrl.sv
// ---------------------------------------------------------------------------
// set_scan_ctrl
// Scan sequencer and tally unit. On an accepted start it latches the set
// operation and both circles, walks every grid point code through the two
// external point-test cells, accumulates the qualifying results, and reports
// the total with a busy/valid handshake.
//   clk, rst                 clock, synchronous active-low reset
//   start                    command strobe, only honoured in IDLE
//   mode                     set operation (latched at start)
//   cx_a, cy_a, r_a          circle A centre/radius (latched at start)
//   cx_b, cy_b, r_b          circle B centre/radius (latched at start)
//   in_a, in_b               registered inside flags from the cells
//   now                      point code to the cells, [x-1] low, [y-1] high
//   en                       cell enable, high only while scanning
//   cell_xa .. cell_rb       latched circle parameters to the cells
//   busy                     high from start acceptance until valid drops
//   valid                    one-cycle pulse, candidate final
//   candidate                qualifying-point count
// ---------------------------------------------------------------------------
module set_scan_ctrl #(
    parameter int GRID_W = 3,
    // Must be 2*GRID_W+1 so the full-map count (2^(2*GRID_W)) fits.
    parameter int CNT_W  = 2 * GRID_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [3:0]            cx_a,
    input  logic [3:0]            cy_a,
    input  logic [3:0]            r_a,
    input  logic [3:0]            cx_b,
    input  logic [3:0]            cy_b,
    input  logic [3:0]            r_b,
    input  logic                  in_a,
    input  logic                  in_b,
    output logic [2*GRID_W-1:0]   now,
    output logic                  en,
    output logic [3:0]            cell_xa,
    output logic [3:0]            cell_ya,
    output logic [3:0]            cell_ra,
    output logic [3:0]            cell_xb,
    output logic [3:0]            cell_yb,
    output logic [3:0]            cell_rb,
    output logic                  busy,
    output logic                  valid,
    output logic [CNT_W-1:0]      candidate
);
    import set_pkg::*;

    localparam int                 PT_W     = 2 * GRID_W;
    localparam logic [PT_W-1:0]    LAST_PT  = {PT_W{1'b1}};
    localparam logic [PT_W-1:0]    PT_ONE   = PT_W'(1);

    state_e              state_q,     state_d;
    logic [1:0]          mode_q,      mode_d;
    logic [PT_W-1:0]     now_q,       now_d;
    logic                en_q,        en_d;
    logic                smp_vld_q,   smp_vld_d;
    logic                drain_q,     drain_d;
    logic                busy_q,      busy_d;
    logic                valid_q,     valid_d;
    logic [CNT_W-1:0]    candidate_q, candidate_d;
    logic [3:0]          cell_xa_q,   cell_xa_d;
    logic [3:0]          cell_ya_q,   cell_ya_d;
    logic [3:0]          cell_ra_q,   cell_ra_d;
    logic [3:0]          cell_xb_q,   cell_xb_d;
    logic [3:0]          cell_yb_q,   cell_yb_d;
    logic [3:0]          cell_rb_q,   cell_rb_d;

    logic                sel;

    set_combine u_combine (
        .mode (mode_q),
        .in_a (in_a),
        .in_b (in_b),
        .sel  (sel)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        now_d       = now_q;
        en_d        = en_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        candidate_d = candidate_q;
        cell_xa_d   = cell_xa_q;
        cell_ya_d   = cell_ya_q;
        cell_ra_d   = cell_ra_q;
        cell_xb_d   = cell_xb_q;
        cell_yb_d   = cell_yb_q;
        cell_rb_d   = cell_rb_q;

        // Cells answer one edge after seeing en, so the tally window is the
        // enable window shifted by one edge.
        smp_vld_d = en_q;
        if (smp_vld_q) begin
            candidate_d = candidate_q + CNT_W'(sel);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    cell_xa_d   = cx_a;
                    cell_ya_d   = cy_a;
                    cell_ra_d   = r_a;
                    cell_xb_d   = cx_b;
                    cell_yb_d   = cy_b;
                    cell_rb_d   = r_b;
                    candidate_d = '0;
                    now_d       = '0;
                    en_d        = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Stop on the last point rather than wrapping back to 0.
                if (now_q == LAST_PT) begin
                    en_d    = 1'b0;
                    drain_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    now_d = now_q + PT_ONE;
                end
            end
            ST_DRAIN: begin
                // Two cycles: one for the last cell result to arrive, one for
                // it to be accumulated.
                if (drain_q) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_A;
            now_q       <= '0;
            en_q        <= 1'b0;
            smp_vld_q   <= 1'b0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            candidate_q <= '0;
            cell_xa_q   <= '0;
            cell_ya_q   <= '0;
            cell_ra_q   <= '0;
            cell_xb_q   <= '0;
            cell_yb_q   <= '0;
            cell_rb_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            now_q       <= now_d;
            en_q        <= en_d;
            smp_vld_q   <= smp_vld_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            candidate_q <= candidate_d;
            cell_xa_q   <= cell_xa_d;
            cell_ya_q   <= cell_ya_d;
            cell_ra_q   <= cell_ra_d;
            cell_xb_q   <= cell_xb_d;
            cell_yb_q   <= cell_yb_d;
            cell_rb_q   <= cell_rb_d;
        end
    end

    assign now       = now_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = candidate_q;
    assign cell_xa   = cell_xa_q;
    assign cell_ya   = cell_ya_q;
    assign cell_ra   = cell_ra_q;
    assign cell_xb   = cell_xb_q;
    assign cell_yb   = cell_yb_q;
    assign cell_rb   = cell_rb_q;

endmodule : set_scan_ctrl

// File: tb/tb_set_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_set_scan_ctrl
// Bench for set_scan_ctrl. Models the two external point-test cells and
// computes expected counts directly from circle geometry over the 8x8 map.
// ---------------------------------------------------------------------------
module tb_set_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [3:0] cx_a, cy_a, r_a, cx_b, cy_b, r_b;
    logic       in_a, in_b;
    logic [5:0] now;
    logic       en;
    logic [3:0] cell_xa, cell_ya, cell_ra, cell_xb, cell_yb, cell_rb;
    logic       busy, valid;
    logic [6:0] candidate;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    set_scan_ctrl #(.GRID_W(3), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .cx_a      (cx_a),
        .cy_a      (cy_a),
        .r_a       (r_a),
        .cx_b      (cx_b),
        .cy_b      (cy_b),
        .r_b       (r_b),
        .in_a      (in_a),
        .in_b      (in_b),
        .now       (now),
        .en        (en),
        .cell_xa   (cell_xa),
        .cell_ya   (cell_ya),
        .cell_ra   (cell_ra),
        .cell_xb   (cell_xb),
        .cell_yb   (cell_yb),
        .cell_rb   (cell_rb),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    // Grid point (x,y), both 1..8, lies inside or on the circle.
    function automatic bit in_circle(input int x, input int y,
                                     input int cx, input int cy, input int r);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= r * r;
    endfunction

    // External point-test cells: one-edge registered result, 0 when disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_a <= 1'b0;
            in_b <= 1'b0;
        end else begin
            in_a <= en && in_circle(int'(now[2:0]) + 1, int'(now[5:3]) + 1,
                                    int'(cell_xa), int'(cell_ya), int'(cell_ra));
            in_b <= en && in_circle(int'(now[2:0]) + 1, int'(now[5:3]) + 1,
                                    int'(cell_xb), int'(cell_yb), int'(cell_rb));
        end
    end

    // Reference: count grid points satisfying the set operation.
    function automatic int ref_count(input int m, input int ax, input int ay, input int ar,
                                     input int bx, input int by, input int br);
        int n;
        bit a, b, s;
        n = 0;
        for (int y = 1; y <= 8; y++) begin
            for (int x = 1; x <= 8; x++) begin
                a = in_circle(x, y, ax, ay, ar);
                b = in_circle(x, y, bx, by, br);
                case (m)
                    0:       s = a;
                    1:       s = a && b;
                    2:       s = a || b;
                    default: s = (a != b);
                endcase
                if (s) n++;
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete run from a single start pulse. With disturb set, start is
    // re-pulsed mid-scan and the live inputs are scrambled; neither may
    // affect the result.
    task automatic do_run(input string tag, input logic [1:0] m,
                          input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] ar,
                          input logic [3:0] bx, input logic [3:0] by, input logic [3:0] br,
                          input int exp, input bit disturb);
        int lat, nval, busy_bad;
        logic [6:0] cand_v;
        lat = -1; nval = 0; busy_bad = 0; cand_v = '0;
        @(negedge clk);
        mode = m; cx_a = ax; cy_a = ay; r_a = ar; cx_b = bx; cy_b = by; r_b = br;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " accept"}, {24'd0, busy, en, now}, {24'd0, 1'b1, 1'b1, 6'd0});
        for (int c = 1; c <= 75; c++) begin
            start = disturb && (c == 10 || c == 40);
            if (disturb && c == 20) begin
                mode = 2'($urandom_range(0, 3));
                cx_a = 4'($urandom); cy_a = 4'($urandom); r_a = 4'($urandom);
                cx_b = 4'($urandom); cy_b = 4'($urandom); r_b = 4'($urandom);
            end
            @(posedge clk); #1;
            if (valid) begin
                nval++;
                if (lat < 0) begin
                    lat    = c;
                    cand_v = candidate;
                end
            end
            if ((c <= 66) != busy) busy_bad++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 66);
        check({tag, " count"}, {25'd0, cand_v}, exp);
        check({tag, " pulses"}, nval, 1);
        check({tag, " busy window"}, busy_bad, 0);
        check({tag, " hold"}, {25'd0, candidate}, exp);
        $display("run %s: mode=%0d A=(%0d,%0d,%0d) B=(%0d,%0d,%0d) candidate=%0d expected=%0d latency=%0d",
                 tag, m, ax, ay, ar, bx, by, br, cand_v, exp, lat);
    endtask

    initial begin
        int nval, last_t, npulse, bad_gap, bad_cand;
        logic [1:0] rm;
        logic [3:0] rax, ray, rar, rbx, rby, rbr;

        rst = 1'b0; start = 1'b0; mode = 2'd0;
        cx_a = 4'd0; cy_a = 4'd0; r_a = 4'd0; cx_b = 4'd0; cy_b = 4'd0; r_b = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", {28'd0, en, busy, valid, 1'b0}, 32'd0);
        check("reset now/cand", {19'd0, now, candidate}, 32'd0);
        check("reset cells", {8'd0, cell_xa, cell_ya, cell_ra, cell_xb, cell_yb, cell_rb}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed geometry cases.
        do_run("A r2", 2'd0, 4'd4, 4'd4, 4'd2, 4'd7, 4'd2, 4'd3, 13, 1'b0);
        do_run("corner", 2'd0, 4'd1, 4'd1, 4'd1, 4'd5, 4'd5, 4'd5, 3, 1'b0);
        do_run("full map", 2'd0, 4'd4, 4'd4, 4'd8, 4'd1, 4'd1, 4'd0, 64, 1'b0);
        do_run("and", 2'd1, 4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 13, 1'b0);
        do_run("or", 2'd2, 4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 13, 1'b0);
        do_run("xor", 2'd3, 4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd2, 0, 1'b0);
        do_run("two pts", 2'd2, 4'd4, 4'd4, 4'd0, 4'd8, 4'd8, 4'd0, 2, 1'b0);

        // Re-pulsed start and scrambled inputs mid-scan.
        do_run("disturb", 2'd0, 4'd4, 4'd4, 4'd2, 4'd2, 4'd2, 4'd1, 13, 1'b1);

        // Randomised circles and modes against the geometric reference.
        for (int k = 0; k < 6; k++) begin
            rm  = 2'($urandom_range(0, 3));
            rax = 4'($urandom_range(1, 8)); ray = 4'($urandom_range(1, 8));
            rar = 4'($urandom_range(0, 6));
            rbx = 4'($urandom_range(1, 8)); rby = 4'($urandom_range(1, 8));
            rbr = 4'($urandom_range(0, 6));
            do_run("random", rm, rax, ray, rar, rbx, rby, rbr,
                   ref_count(int'(rm), int'(rax), int'(ray), int'(rar),
                             int'(rbx), int'(rby), int'(rbr)), 1'b0);
        end

        // Reset in the middle of a scan aborts it without a valid pulse.
        @(negedge clk);
        mode = 2'd0; cx_a = 4'd4; cy_a = 4'd4; r_a = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort ctl", {29'd0, en, busy, valid}, 32'd0);
        check("abort now/cand", {19'd0, now, candidate}, 32'd0);
        nval = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (valid || busy) nval++;
        end
        check("abort quiet", nval, 0);
        $display("abort: reset at scan cycle 30, activity after abort=%0d", nval);
        do_run("after abort", 2'd0, 4'd4, 4'd4, 4'd2, 4'd1, 4'd1, 4'd1, 13, 1'b0);

        // Start held high: runs repeat with one IDLE cycle between them, so
        // valid pulses recur every 68 edges (67 cycles between pulses).
        @(negedge clk);
        mode = 2'd0; cx_a = 4'd4; cy_a = 4'd4; r_a = 4'd2;
        start = 1'b1;
        npulse = 0; last_t = -1; bad_gap = 0; bad_cand = 0;
        for (int t = 0; t <= 210; t++) begin
            if (t > 200) start = 1'b0;
            @(posedge clk); #1;
            if (valid) begin
                npulse++;
                if (candidate !== 7'd13) bad_cand++;
                if (last_t >= 0 && (t - last_t) != 68) bad_gap++;
                $display("held start: valid at edge %0d candidate=%0d", t, candidate);
                last_t = t;
            end
        end
        start = 1'b0;
        check("held pulses", npulse, 3);
        check("held spacing", bad_gap, 0);
        check("held count", bad_cand, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_set_scan_ctrl
